// File: rtl/rtm_sequencer.sv
// Micro-instruction sequencer for the 4x4-bit register-transfer datapath.
// Each accepted instruction runs SETUP (SETUP_CYCLES) -> STROBE (1) -> HOLD (1);
// controls are registered on SETUP entry and held so reg_we only rises on settled
// mux/adder outputs. The adder carry is captured on STROBE exit to feed ADDC chains.
module rtm_sequencer #(
   parameter int unsigned SETUP_CYCLES = 1,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [11:0]      instr,
   input  logic             carry_out,
   output logic [1:0]       ctl_d,
   output logic [1:0]       ctl_sa,
   output logic [1:0]       ctl_sb,
   output logic             ctl_add,
   output logic             carry_in,
   output logic [3:0]       indata,
   output logic             reg_we,
   output logic             dp_clear_n,
   output logic             carry_flag,
   output logic             done,
   output logic             busy,
   output logic [CNT_W-1:0] retired
);

   localparam int unsigned CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
   localparam logic [CW-1:0] CntLoad = CW'(SETUP_CYCLES - 1);

   localparam logic [1:0] OpLoad = 2'b00;
   localparam logic [1:0] OpAdd  = 2'b01;
   localparam logic [1:0] OpAddc = 2'b10;
   localparam logic [1:0] OpClr  = 2'b11;

   typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

   state_e          state;
   logic [1:0]      op;
   logic [CW-1:0]   cnt;
   logic            accept;
   logic [1:0]      new_op;

   // instr_ready is only high in IDLE and HOLD, so this is the full handshake
   assign accept = instr_valid & instr_ready;
   assign new_op = instr[11:10];

   // Sequencer FSM; every output is a register so controls never glitch
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state       <= StIdle;
         op          <= OpLoad;
         cnt         <= '0;
         instr_ready <= 1'b1;
         ctl_d       <= 2'b00;
         ctl_sa      <= 2'b00;
         ctl_sb      <= 2'b00;
         ctl_add     <= 1'b0;
         carry_in    <= 1'b0;
         indata      <= 4'h0;
         reg_we      <= 1'b0;
         dp_clear_n  <= 1'b1;
         carry_flag  <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         retired     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
            end
            StSetup: begin
               if (cnt == '0) begin
                  state      <= StStrobe;
                  reg_we     <= (op != OpClr);
                  dp_clear_n <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StStrobe: begin
               state       <= StHold;
               reg_we      <= 1'b0;
               done        <= 1'b1;
               retired     <= retired + 1'b1;
               instr_ready <= 1'b1;
               if (op == OpAdd || op == OpAddc) begin
                  carry_flag <= carry_out;
               end else if (op == OpClr) begin
                  carry_flag <= 1'b0;
               end
            end
            StHold: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: state <= StIdle;
         endcase
         // Acceptance overrides the HOLD->IDLE exit to give back-to-back issue
         if (accept) begin
            state       <= StSetup;
            op          <= new_op;
            cnt         <= CntLoad;
            busy        <= 1'b1;
            instr_ready <= 1'b0;
            ctl_d       <= instr[9:8];
            ctl_sa      <= instr[7:6];
            ctl_sb      <= instr[5:4];
            indata      <= instr[3:0];
            ctl_add     <= (new_op == OpAdd) || (new_op == OpAddc);
            carry_in    <= (new_op == OpAddc) ? carry_flag : 1'b0;
            dp_clear_n  <= (new_op != OpClr);
         end
      end
   end

endmodule
